bus_trace_buffer: RTL and testbench

- Debug capture block downstream of top_6502C; consumes the CPU external bus (extAB, extDB, RW, SYNC) once per completed bus cycle.
- Records cycles into a circular trace RAM with an address-match trigger and programmable post-trigger depth.
- After capture stops, the trace is read out oldest-first through a simple read handshake.
- Used for on-board and sim debug of instruction sequencing alongside memory256x256.

---
 rtl/bus_trace_buffer.sv | 140 ++++++++++++++
 tb/tb_bus_trace_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_trace_buffer.sv
// Bus trace buffer: circular capture of CPU bus cycles with an address-match
// trigger, programmable post-trigger depth, and oldest-first readout.
module bus_trace_buffer #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clock,
    input  logic                  RES_L,
    input  logic                  cyc_en,
    input  logic                  SYNC,
    input  logic                  RW,
    input  logic [15:0]           extAB,
    input  logic [7:0]            extDB,
    input  logic                  arm,
    input  logic [15:0]           trig_addr,
    input  logic                  trig_sync_only,
    input  logic [DEPTH_LOG2:0]   post_count,
    input  logic                  rd_en,
    output logic [25:0]           rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic [1:0]            state,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_TRIG  = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2-1:0] rem_q, rem_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [25:0]           rdat_q, rdat_d;
    logic                  rval_q, rval_d;

    logic [25:0]           mem [DEPTH];

    logic                  capture, match, rd_ok, full;
    logic [DEPTH_LOG2-1:0] post_clamp;

    // arm wins over everything else in the same clock, so it masks capture and reads
    assign capture    = cyc_en & ~arm & ((state_q == S_ARMED) | (state_q == S_TRIG));
    assign match      = capture & (state_q == S_ARMED) & (extAB == trig_addr) &
                        (~trig_sync_only | SYNC);
    assign rd_ok      = rd_en & ~arm & ((state_q == S_IDLE) | (state_q == S_DONE)) &
                        (cnt_q != '0);
    assign full       = (cnt_q == DEPTH_C);
    // clamping to DEPTH-1 keeps the trigger entry from being overwritten
    assign post_clamp = (post_count >= DEPTH_C) ? {DEPTH_LOG2{1'b1}}
                                                : post_count[DEPTH_LOG2-1:0];

    // Next-state: arm clear, capture with overwrite-oldest, trigger countdown, readout
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        rdat_d  = rdat_q;
        rval_d  = 1'b0;
        if (arm) begin
            wptr_d  = '0;
            rptr_d  = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = S_ARMED;
        end else begin
            if (capture) begin
                wptr_d = wptr_q + 1'b1;
                if (full) begin
                    rptr_d = rptr_q + 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            case (state_q)
                S_ARMED: if (match) begin
                    rem_d   = post_clamp;
                    state_d = (post_clamp == '0) ? S_DONE : S_TRIG;
                end
                S_TRIG: if (capture) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q <= 1) state_d = S_DONE;
                end
                default: ;
            endcase
            if (rd_ok) begin
                rdat_d = mem[rptr_q];
                rval_d = 1'b1;
                rptr_d = rptr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clock or negedge RES_L) begin
        if (!RES_L) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rdat_q  <= '0;
            rval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rdat_q  <= rdat_d;
            rval_q  <= rval_d;
        end
    end

    // Trace RAM write port; contents need no reset since count gates every read
    always_ff @(posedge clock) begin
        if (capture) mem[wptr_q] <= {SYNC, RW, extAB, extDB};
    end

    assign rd_data  = rdat_q;
    assign rd_valid = rval_q;
    assign count    = cnt_q;
    assign state    = state_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Bench for bus_trace_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bus_trace_buffer;

    localparam int DL    = 6;
    localparam int DEPTH = 1 << DL;

    logic          clock = 0;
    logic          RES_L = 0;
    logic          cyc_en = 0, SYNC = 0, RW = 0, arm = 0, trig_sync_only = 0, rd_en = 0;
    logic [15:0]   extAB = 0, trig_addr = 0;
    logic [7:0]    extDB = 0;
    logic [DL:0]   post_count = 0;
    logic [25:0]   rd_data;
    logic          rd_valid;
    logic [DL:0]   count;
    logic [1:0]    state;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    bus_trace_buffer #(.DEPTH_LOG2(DL)) dut (
        .clock(clock), .RES_L(RES_L), .cyc_en(cyc_en), .SYNC(SYNC), .RW(RW),
        .extAB(extAB), .extDB(extDB), .arm(arm), .trig_addr(trig_addr),
        .trig_sync_only(trig_sync_only), .post_count(post_count), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .state(state),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the trace is a queue holding at most DEPTH entries
    logic [25:0] mq[$];
    int          m_state, m_rem;
    bit          m_ovf, m_rvalid;
    logic [25:0] m_rdata;

    always @(posedge clock or negedge RES_L) begin
        if (!RES_L) begin
            mq.delete();
            m_state = 0; m_rem = 0; m_ovf = 0; m_rdata = '0; m_rvalid = 0;
        end else begin
            int st0;
            st0 = m_state;
            m_rvalid = 0;
            if (arm) begin
                mq.delete();
                m_ovf = 0;
                m_state = 1;
            end else begin
                if (cyc_en && (st0 == 1 || st0 == 2)) begin
                    mq.push_back({SYNC, RW, extAB, extDB});
                    if (mq.size() > DEPTH) begin
                        void'(mq.pop_front());
                        m_ovf = 1;
                    end
                    if (st0 == 1 && extAB == trig_addr && (!trig_sync_only || SYNC)) begin
                        int pc;
                        pc = int'(post_count);
                        m_rem = (pc > DEPTH - 1) ? DEPTH - 1 : pc;
                        m_state = (m_rem == 0) ? 3 : 2;
                    end else if (st0 == 2) begin
                        m_rem--;
                        if (m_rem == 0) m_state = 3;
                    end
                end
                if (rd_en && (st0 == 0 || st0 == 3) && mq.size() > 0) begin
                    m_rdata  = mq.pop_front();
                    m_rvalid = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        check("state",    32'(state),    32'(m_state[1:0]));
        check("count",    32'(count),    32'(mq.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rd_valid", 32'(rd_valid), 32'(m_rvalid));
        check("rd_data",  32'(rd_data),  32'(m_rdata));
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic bus(input logic [15:0] ab, input logic s);
        cyc_en = 1; extAB = ab; SYNC = s; RW = 1'($urandom); extDB = 8'($urandom);
        tick();
        cyc_en = 0;
    endtask

    task automatic do_arm(input logic [15:0] ta, input logic so, input logic [DL:0] pc);
        trig_addr = ta; trig_sync_only = so; post_count = pc;
        arm = 1; tick(); arm = 0;
    endtask

    task automatic pop(output logic [25:0] d, output logic v);
        rd_en = 1; tick(); rd_en = 0;
        d = rd_data; v = rd_valid;
    endtask

    logic [25:0] d;
    logic        v;
    logic [15:0] exp2 [14];

    initial begin
        exp2 = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0204, 16'h0205, 16'h0206,
                 16'h0207, 16'h0208, 16'h0209, 16'hFFFC, 16'h0300, 16'h0301, 16'h0302};
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", 32'(state), 0);
        check("reset_count", 32'(count), 0);
        RES_L = 1;
        tick();

        // Basic trigger with post_count=3
        do_arm(16'hFFFC, 0, 3);
        check("armed_state", 32'(state), 1);
        for (int i = 0; i < 10; i++) bus(16'h0200 + 16'(i), 0);
        bus(16'hFFFC, 0);
        check("trig_state", 32'(state), 2);
        for (int i = 0; i < 6; i++) begin
            bus(16'h0300 + 16'(i), 0);
            if (i == 2) check("done_after_0302", 32'(state), 3);
        end
        check("done_count14", 32'(count), 14);
        for (int i = 0; i < 14; i++) begin
            pop(d, v);
            check("rd2_valid", 32'(v), 1);
            check("rd2_addr", 32'(d[23:8]), 32'(exp2[i]));
        end
        pop(d, v);
        check("rd_empty_novalid", 32'(v), 0);
        check("rd_empty_hold", 32'(d[23:8]), 32'h0302);

        // SYNC-qualified trigger
        do_arm(16'h1234, 1, 2);
        bus(16'h1000, 1); bus(16'h1234, 0); bus(16'h1001, 0);
        check("sync0_no_trig", 32'(state), 1);
        bus(16'h1234, 1); bus(16'h1002, 0); bus(16'h1003, 0); bus(16'h1004, 0);
        check("sync_done", 32'(state), 3);
        check("sync_count", 32'(count), 6);
        pop(d, v); pop(d, v);
        check("sync0_entry_addr", 32'(d[23:8]), 32'h1234);
        check("sync0_entry_sync", 32'(d[25]), 0);

        // Overflow: 100 pre-trigger cycles, post_count=0
        do_arm(16'hBEEF, 0, 0);
        for (int i = 1; i <= 100; i++) bus(16'(i), 0);
        bus(16'hBEEF, 0);
        check("ovf_state", 32'(state), 3);
        check("ovf_count", 32'(count), 64);
        check("ovf_flag", 32'(overflow), 1);
        for (int i = 0; i < 64; i++) begin
            pop(d, v);
            check("ovf_rd_addr", 32'(d[23:8]), (i < 63) ? 32'(38 + i) : 32'hBEEF);
        end
        check("ovf_sticky", 32'(overflow), 1);

        // Oversized post_count clamps to DEPTH-1
        do_arm(16'h4444, 0, 7'd100);
        for (int i = 0; i < 5; i++) bus(16'h4000 + 16'(i), 0);
        bus(16'h4444, 0);
        for (int i = 0; i < 70; i++) begin
            bus(16'h5000 + 16'(i), 0);
            if (i == 61) check("clamp_not_done", 32'(state), 2);
            if (i == 62) check("clamp_done", 32'(state), 3);
        end
        check("clamp_count", 32'(count), 64);
        pop(d, v);
        check("clamp_first_trig", 32'(d[23:8]), 32'h4444);

        // arm + cyc_en in TRIG: re-arm, cycle not captured
        do_arm(16'h7777, 0, 10);
        bus(16'h7777, 0); bus(16'h7001, 0);
        cyc_en = 1; extAB = 16'h7002; arm = 1; tick(); cyc_en = 0; arm = 0;
        check("rearm_state", 32'(state), 1);
        check("rearm_count", 32'(count), 0);
        rd_en = 1; tick(); rd_en = 0;
        check("rd_in_armed_ignored", 32'(rd_valid), 0);
        do_arm(16'h7777, 0, 0);
        bus(16'h7777, 0);
        pop(d, v); pop(d, v);
        check("done_empty_novalid", 32'(v), 0);

        // Async reset mid-TRIG with count=20
        do_arm(16'h0AAA, 0, 50);
        for (int i = 0; i < 10; i++) bus(16'h0100 + 16'(i), 0);
        bus(16'h0AAA, 0);
        for (int i = 0; i < 9; i++) bus(16'h0110 + 16'(i), 0);
        check("pre_rst_count", 32'(count), 20);
        #2 RES_L = 0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_rvalid", 32'(rd_valid), 0);
        tick(); RES_L = 1; tick();
        pop(d, v);
        check("post_rst_rd", 32'(v), 0);

        // Randomized traffic against the model
        trig_addr = 16'h2A2A;
        for (int i = 0; i < 6000; i++) begin
            arm    = ($urandom_range(0, 149) == 0);
            cyc_en = 1'($urandom_range(0, 1));
            extAB  = ($urandom_range(0, 7) == 0) ? trig_addr : 16'($urandom);
            SYNC   = 1'($urandom);
            RW     = 1'($urandom);
            extDB  = 8'($urandom);
            rd_en  = ($urandom_range(0, 2) != 0);
            post_count = 7'($urandom_range(0, 127));
            if (arm) trig_sync_only = 1'($urandom);
            tick();
        end
        arm = 0; cyc_en = 0; rd_en = 0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

endmodule
